memory_controller: RTL and testbench

//  Responder side of the CPU's memory request handshake. Serves word/half/byte

---
 rtl/memory_controller_if.sv | 29 ++
 rtl/memory_controller.sv | 209 ++++++++++++++++++++
 tb/tb_memory_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_if.sv
// Request/response handshake to the LSB and fetch unit, plus the byte-wide RAM/IO bus.
// The slave modport is the controller's view; master is the surrounding system's view.
interface memory_controller_if;
  logic        lsbFlag;
  logic [2:0]  lsbOp;
  logic [31:0] lsbAddr;
  logic [31:0] lsbDataIn;
  logic [31:0] lsbDataOut;
  logic        lsbOkFlag;
  logic        ifFlag;
  logic [31:0] ifAddr;
  logic [31:0] ifData;
  logic        ifOkFlag;
  logic [7:0]  memIn;
  logic [7:0]  memOut;
  logic [31:0] memA;
  logic        memWr;
  logic        ioBufferFull;

  modport slave (
    input  lsbFlag, lsbOp, lsbAddr, lsbDataIn, ifFlag, ifAddr, memIn, ioBufferFull,
    output lsbDataOut, lsbOkFlag, ifData, ifOkFlag, memOut, memA, memWr
  );

  modport master (
    output lsbFlag, lsbOp, lsbAddr, lsbDataIn, ifFlag, ifAddr, memIn, ioBufferFull,
    input  lsbDataOut, lsbOkFlag, ifData, ifOkFlag, memOut, memA, memWr
  );
endinterface

// File: rtl/memory_controller.sv
// Serialises one LSB (byte/half/word) or fetch (4-byte) request at a time onto a
// byte-wide synchronous RAM/IO bus and returns a one-cycle ok pulse with the data.
module memory_controller #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic clockIn,
  input  logic resetIn,
  input  logic readyIn,
  memory_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_out_q, mem_out_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] lsb_data_q, lsb_data_d;
  logic [31:0] if_data_q, if_data_d;
  logic        lsb_ok_q, lsb_ok_d;
  logic        if_ok_q, if_ok_d;
  logic        src_lsb_q, src_lsb_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  k_q, k_d;
  logic [2:0]  issue_q, issue_d;
  logic        avld_q, avld_d;
  logic        pend_q, pend_d;
  logic        stalled_q, stalled_d;

  logic        acc_lsb;
  logic [31:0] acc_addr;
  logic        acc_store;
  logic [1:0]  acc_last;
  logic        io_blk;
  logic [1:0]  k_inc;
  logic [31:0] rbuf_merged;

  assign acc_lsb   = bus.lsbFlag;
  assign acc_addr  = acc_lsb ? bus.lsbAddr : bus.ifAddr;
  assign acc_store = acc_lsb & bus.lsbOp[2];
  assign acc_last  = !acc_lsb                 ? 2'd3 :
                     (bus.lsbOp[1:0] == 2'b00) ? 2'd0 :
                     (bus.lsbOp[1:0] == 2'b01) ? 2'd1 : 2'd3;

  assign io_blk      = (mem_a_q >= IO_BASE) && bus.ioBufferFull;
  assign k_inc       = k_q + 2'd1;
  assign rbuf_merged = rbuf_q | ({24'b0, bus.memIn} << {k_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_out_d  = mem_out_q;
    mem_wr_d   = mem_wr_q;
    lsb_data_d = lsb_data_q;
    if_data_d  = if_data_q;
    lsb_ok_d   = lsb_ok_q;
    if_ok_d    = if_ok_q;
    src_lsb_d  = src_lsb_q;
    last_d     = last_q;
    k_d        = k_q;
    issue_d    = issue_q;
    avld_d     = avld_q;
    pend_d     = pend_q;
    stalled_d  = stalled_q;

    if (!readyIn) begin
      stalled_d = 1'b1;
    end else begin
      stalled_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          mem_wr_d = 1'b0;
          if (bus.lsbFlag || bus.ifFlag) begin
            src_lsb_d = acc_lsb;
            addr_d    = acc_addr;
            wdata_d   = bus.lsbDataIn;
            last_d    = acc_last;
            mem_a_d   = acc_addr;
            k_d       = 2'd0;
            if (acc_store) begin
              mem_out_d = bus.lsbDataIn[7:0];
              mem_wr_d  = 1'b1;
              state_d   = S_WRITE;
            end else begin
              rbuf_d  = '0;
              issue_d = 3'd1;
              avld_d  = 1'b1;
              pend_d  = 1'b0;
              state_d = S_READ;
            end
          end
        end

        S_WRITE: begin
          if (!io_blk) begin
            if (k_q == last_q) begin
              mem_wr_d = 1'b0;
              lsb_ok_d = src_lsb_q;
              if_ok_d  = !src_lsb_q;
              state_d  = S_DONE;
            end else begin
              k_d       = k_inc;
              mem_a_d   = mem_a_q + 32'd1;
              mem_out_d = wdata_q[{k_inc, 3'b000} +: 8];
            end
          end
        end

        S_READ: begin
          if (stalled_q) begin
            // The byte in flight across a freeze is lost; re-issue from the first uncaptured byte.
            pend_d  = 1'b0;
            avld_d  = 1'b1;
            mem_a_d = addr_q + {30'b0, k_q};
            issue_d = {1'b0, k_q} + 3'd1;
          end else begin
            pend_d = avld_q;
            if (issue_q <= {1'b0, last_q}) begin
              mem_a_d = addr_q + {29'b0, issue_q};
              issue_d = issue_q + 3'd1;
              avld_d  = 1'b1;
            end else begin
              avld_d = 1'b0;
            end
            if (pend_q) begin
              rbuf_d = rbuf_merged;
              k_d    = k_inc;
              if (k_q == last_q) begin
                avld_d   = 1'b0;
                pend_d   = 1'b0;
                lsb_ok_d = src_lsb_q;
                if_ok_d  = !src_lsb_q;
                if (src_lsb_q) lsb_data_d = rbuf_merged;
                else           if_data_d  = rbuf_merged;
                state_d  = S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          lsb_ok_d = 1'b0;
          if_ok_d  = 1'b0;
          state_d  = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      mem_a_q    <= '0;
      mem_out_q  <= '0;
      mem_wr_q   <= 1'b0;
      lsb_data_q <= '0;
      if_data_q  <= '0;
      lsb_ok_q   <= 1'b0;
      if_ok_q    <= 1'b0;
      src_lsb_q  <= 1'b0;
      last_q     <= '0;
      k_q        <= '0;
      issue_q    <= '0;
      avld_q     <= 1'b0;
      pend_q     <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_out_q  <= mem_out_d;
      mem_wr_q   <= mem_wr_d;
      lsb_data_q <= lsb_data_d;
      if_data_q  <= if_data_d;
      lsb_ok_q   <= lsb_ok_d;
      if_ok_q    <= if_ok_d;
      src_lsb_q  <= src_lsb_d;
      last_q     <= last_d;
      k_q        <= k_d;
      issue_q    <= issue_d;
      avld_q     <= avld_d;
      pend_q     <= pend_d;
      stalled_q  <= stalled_d;
    end
  end

  // Write strobe and ok pulses are suppressed while frozen or while the IO buffer blocks.
  assign bus.memWr      = mem_wr_q & readyIn & ~io_blk;
  assign bus.lsbOkFlag  = lsb_ok_q & readyIn;
  assign bus.ifOkFlag   = if_ok_q & readyIn;
  assign bus.memA       = mem_a_q;
  assign bus.memOut     = mem_out_q;
  assign bus.lsbDataOut = lsb_data_q;
  assign bus.ifData     = if_data_q;

endmodule

// File: tb/tb_memory_controller.sv
// Randomised bench for memory_controller: a byte RAM on the bus, and a reference
// memory that predicts load data, store effects and completion latency.
module tb_memory_controller;
  localparam logic [31:0] IO_BASE = 32'h30000;

  logic clk = 1'b0;
  logic resetIn, readyIn;
  memory_controller_if bif();

  memory_controller #(.IO_BASE(IO_BASE)) dut (
    .clockIn (clk),
    .resetIn (resetIn),
    .readyIn (readyIn),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] bram    [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  logic [31:0] sa [64];
  logic        sw [64];
  logic [7:0]  so [64];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] bram_rd(input logic [31:0] a);
    return bram.exists(a) ? bram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic int nbytes(input bit is_if, input logic [2:0] op);
    if (is_if) return 4;
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_exp(input logic [31:0] a, input int n);
    logic [31:0] e = '0;
    for (int i = 0; i < n; i++) e = e | ({24'b0, ref_rd(a + i)} << (8 * i));
    return e;
  endfunction

  // Store completes one cycle after its last byte; each IO byte waits out ioBufferFull.
  function automatic int store_lat(input logic [31:0] a, input int n, input int io_n);
    int c = 1;
    for (int i = 0; i < n; i++) begin
      while ((a + i) >= IO_BASE && c <= io_n) c++;
      c++;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (bif.memWr) bram[bif.memA] = bif.memOut;
    bif.memIn <= bram_rd(bif.memA);
  end

  task automatic xfer(input bit use_if, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input int io_n, input int st_s,
                      input int st_len, input int rst_c, output logic [31:0] rdata,
                      output int lat, output int oks, output int wrs);
    int post = 0;
    rdata = '0; lat = 0; oks = 0; wrs = 0;
    @(negedge clk);
    readyIn = 1'b1; resetIn = 1'b0; bif.ioBufferFull = 1'b0;
    if (use_if) begin
      bif.ifFlag = 1'b1; bif.ifAddr = addr;
    end else begin
      bif.lsbFlag = 1'b1; bif.lsbOp = op; bif.lsbAddr = addr; bif.lsbDataIn = wdata;
    end
    for (int c = 1; c < 60 && post < 4; c++) begin
      @(negedge clk);
      readyIn          = !(c >= st_s && c < st_s + st_len);
      bif.ioBufferFull = (c <= io_n);
      resetIn          = (c == rst_c);
      if (c == rst_c) begin bif.lsbFlag = 1'b0; bif.ifFlag = 1'b0; end
      #1;
      sa[c] = bif.memA; sw[c] = bif.memWr; so[c] = bif.memOut;
      if (bif.memWr) wrs++;
      if (use_if ? bif.ifOkFlag : bif.lsbOkFlag) begin
        oks++;
        if (lat == 0) begin
          lat   = c;
          rdata = use_if ? bif.ifData : bif.lsbDataOut;
        end
        bif.lsbFlag = 1'b0; bif.ifFlag = 1'b0;
      end
      if (lat != 0 || (rst_c > 0 && c > rst_c)) post++;
    end
    @(negedge clk);
    readyIn = 1'b1; resetIn = 1'b0; bif.ioBufferFull = 1'b0;
    bif.lsbFlag = 1'b0; bif.ifFlag = 1'b0;
  endtask

  logic [31:0] rd;
  int lat, oks, wrs;

  initial begin
    resetIn = 1'b1; readyIn = 1'b1;
    bif.lsbFlag = 1'b0; bif.lsbOp = '0; bif.lsbAddr = '0; bif.lsbDataIn = '0;
    bif.ifFlag = 1'b0; bif.ifAddr = '0; bif.ioBufferFull = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memA", bif.memA, 32'h0);
    chk("rst_memOut", {24'b0, bif.memOut}, 32'h0);
    chk("rst_memWr", {31'b0, bif.memWr}, 32'h0);
    chk("rst_lsbOk", {31'b0, bif.lsbOkFlag}, 32'h0);
    chk("rst_ifOk", {31'b0, bif.ifOkFlag}, 32'h0);
    chk("rst_lsbData", bif.lsbDataOut, 32'h0);
    chk("rst_ifData", bif.ifData, 32'h0);
    resetIn = 1'b0;

    for (int unsigned i = 0; i < 4; i++) begin
      bram[32'h100 + i]    = 8'(8'h11 * (i + 1));
      ref_mem[32'h100 + i] = 8'(8'h11 * (i + 1));
    end

    // Word load
    xfer(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0, 0, rd, lat, oks, wrs);
    chk("t1_data", rd, 32'h44332211);
    chk("t1_lat", 32'(lat), 32'd6);
    chk("t1_oks", 32'(oks), 32'd1);
    for (int i = 1; i <= 4; i++) chk("t1_memA", sa[i], 32'h100 + 32'(i - 1));

    // Half store
    xfer(1'b0, 3'b101, 32'h200, 32'hDEADBEEF, 0, 0, 0, 0, rd, lat, oks, wrs);
    ref_mem[32'h200] = 8'hEF; ref_mem[32'h201] = 8'hBE;
    chk("t2_wr1", {sw[1], sa[1][22:0], so[1]}, {1'b1, 23'h200, 8'hEF});
    chk("t2_wr2", {sw[2], sa[2][22:0], so[2]}, {1'b1, 23'h201, 8'hBE});
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_wrs", 32'(wrs), 32'd2);
    chk("t2_ram202", {24'b0, bram_rd(32'h202)}, {24'b0, ref_rd(32'h202)});

    // Simultaneous LSB and fetch
    begin
      int l_c = 0, f_c = 0, lo = 0, fo = 0;
      logic [31:0] ldat = '0, fdat = '0;
      @(negedge clk);
      bif.lsbFlag = 1'b1; bif.lsbOp = 3'b010; bif.lsbAddr = 32'h100;
      bif.ifFlag = 1'b1; bif.ifAddr = 32'h1000;
      for (int c = 1; c < 60 && !(f_c != 0 && c > f_c + 3); c++) begin
        @(negedge clk); #1;
        if (bif.lsbOkFlag) begin
          lo++; if (l_c == 0) begin l_c = c; ldat = bif.lsbDataOut; end
          bif.lsbFlag = 1'b0;
        end
        if (bif.ifOkFlag) begin
          fo++; if (f_c == 0) begin f_c = c; fdat = bif.ifData; end
          bif.ifFlag = 1'b0;
        end
      end
      bif.lsbFlag = 1'b0; bif.ifFlag = 1'b0;
      chk("t3_lsb_lat", 32'(l_c), 32'd6);
      chk("t3_if_lat", 32'(f_c), 32'd13);
      chk("t3_lsb_data", ldat, load_exp(32'h100, 4));
      chk("t3_if_data", fdat, load_exp(32'h1000, 4));
      chk("t3_lsb_oks", 32'(lo), 32'd1);
      chk("t3_if_oks", 32'(fo), 32'd1);
    end

    // Byte store into IO space while the buffer is full for three cycles
    xfer(1'b0, 3'b100, IO_BASE, 32'h0000005C, 3, 0, 0, 0, rd, lat, oks, wrs);
    ref_mem[IO_BASE] = 8'h5C;
    for (int i = 1; i <= 3; i++) chk("t4_blocked", {31'b0, sw[i]}, 32'h0);
    chk("t4_wr", {sw[4], sa[4][22:0], so[4]}, {1'b1, IO_BASE[22:0], 8'h5C});
    chk("t4_lat", 32'(lat), 32'd5);
    chk("t4_ram", {24'b0, bram_rd(IO_BASE)}, 32'h5C);

    // Freeze mid word load
    xfer(1'b0, 3'b010, 32'h100, 32'h0, 0, 3, 2, 0, rd, lat, oks, wrs);
    chk("t5_data", rd, 32'h44332211);
    chk("t5_oks", 32'(oks), 32'd1);
    chk("t5_wrs", 32'(wrs), 32'd0);

    // Reset after two bytes of a word store, then a clean fetch
    xfer(1'b0, 3'b110, 32'h400, 32'h11223344, 0, 0, 0, 2, rd, lat, oks, wrs);
    ref_mem[32'h400] = 8'h44; ref_mem[32'h401] = 8'h33;
    chk("t6_oks", 32'(oks), 32'd0);
    chk("t6_wrs", 32'(wrs), 32'd2);
    chk("t6_wr_after", {31'b0, sw[3]}, 32'h0);
    for (int unsigned i = 0; i < 4; i++)
      chk("t6_ram", {24'b0, bram_rd(32'h400 + i)}, {24'b0, ref_rd(32'h400 + i)});
    xfer(1'b1, 3'b000, 32'h100, 32'h0, 0, 0, 0, 0, rd, lat, oks, wrs);
    chk("t6_fetch", rd, 32'h44332211);
    chk("t6_fetch_lat", 32'(lat), 32'd6);

    // Randomised mix
    for (int t = 0; t < 60; t++) begin
      bit          is_if  = ($urandom_range(0, 2) == 0);
      logic [2:0]  op     = {1'b0, 2'($urandom_range(0, 3))};
      logic [31:0] a;
      logic [31:0] wd     = $urandom;
      int          io_n   = $urandom_range(0, 3);
      bit          stall  = ($urandom_range(0, 3) == 0);
      int          st_s   = stall ? $urandom_range(1, 6) : 0;
      int          st_len = stall ? $urandom_range(1, 3) : 0;
      int          n;
      logic [31:0] exp;
      op[2] = !is_if && $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       a = 32'h1000 + $urandom_range(0, 63);
        1:       a = IO_BASE + $urandom_range(0, 63);
        2:       a = 32'hFFFFFFFC + $urandom_range(0, 3);
        default: a = IO_BASE - 32'd3 + $urandom_range(0, 2);
      endcase
      n = nbytes(is_if, op);
      exp = load_exp(a, n);
      xfer(is_if, op, a, wd, io_n, st_s, st_len, 0, rd, lat, oks, wrs);
      chk("r_oks", 32'(oks), 32'd1);
      if (op[2]) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
        chk("r_wrs", 32'(wrs), 32'(n));
        if (!stall) chk("r_st_lat", 32'(lat), 32'(store_lat(a, n, io_n)));
        for (int i = 0; i <= n; i++)
          chk("r_ram", {24'b0, bram_rd(a + i)}, {24'b0, ref_rd(a + i)});
      end else begin
        chk("r_rdata", rd, exp);
        chk("r_rd_wrs", 32'(wrs), 32'd0);
        if (!stall) chk("r_ld_lat", 32'(lat), 32'(n + 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
